// File: rtl/sweeper_pkg.sv
// Shared definitions for the truth-table sweeper: FSM state codes,
// signature width and the signature rotate helper.
package sweeper_pkg;

  localparam int SIG_W = 32;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETTLE = 2'd1;
  localparam state_t ST_FINISH = 2'd2;

  // Rotate left by one bit; the signature shifts each new sample in at bit 0.
  function automatic logic [SIG_W-1:0] rotl1(input logic [SIG_W-1:0] v);
    return {v[SIG_W-2:0], v[SIG_W-1]};
  endfunction

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// Settle-window timer: counts cycles while run is high and flags the last
// cycle of the window so the caller can sample and move on.
module settle_timer #(
  parameter int SETTLE_CYCLES = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

  logic [CW-1:0] count_r;

  // Window counter: cleared between vectors, advances once per cycle while running.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {CW{1'b0}};
    end else if (clear) begin
      count_r <= {CW{1'b0}};
    end else if (run) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expire = (count_r == LAST);

endmodule

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: drives every input vector in ascending order, holds
// each for a settle window, samples the circuit response at the end of the
// window, streams it out and folds it into a signature and a ones-count.
module truth_table_sweeper
  import sweeper_pkg::*;
#(
  parameter int N_IN          = 3,
  parameter int N_OUT         = 1,
  parameter int SETTLE_CYCLES = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [N_IN-1:0]   vec_out,
  input  logic [N_OUT-1:0]  dut_out,
  output logic              busy,
  output logic              sample_valid,
  output logic [N_IN-1:0]   sample_index,
  output logic [N_OUT-1:0]  sample_data,
  output logic              done,
  output logic [SIG_W-1:0]  signature,
  output logic [N_IN:0]     ones_count
);

  state_t state_r;
  logic   run_s;
  logic   clear_s;
  logic   expire_s;
  logic   last_vec_s;

  // The timer only runs in SETTLE and restarts at every vector boundary.
  assign run_s      = (state_r == ST_SETTLE);
  assign clear_s    = (~run_s) | expire_s;
  assign last_vec_s = &vec_out;

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear_s),
    .run    (run_s),
    .expire (expire_s)
  );

  // Sweep FSM, vector counter, sample stream and accumulators.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      vec_out      <= {N_IN{1'b0}};
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      sample_index <= {N_IN{1'b0}};
      sample_data  <= {N_OUT{1'b0}};
      done         <= 1'b0;
      signature    <= {SIG_W{1'b0}};
      ones_count   <= {(N_IN+1){1'b0}};
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      sample_valid <= 1'b0;
      done         <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r    <= ST_SETTLE;
            vec_out    <= {N_IN{1'b0}};
            busy       <= 1'b1;
            signature  <= {SIG_W{1'b0}};
            ones_count <= {(N_IN+1){1'b0}};
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SETTLE: begin
          if (abort) begin
            // Abort beats a coincident sample: the partial vector is dropped.
            state_r <= ST_IDLE;
            vec_out <= {N_IN{1'b0}};
            busy    <= 1'b0;
          end else if (expire_s) begin
            sample_valid <= 1'b1;
            sample_index <= vec_out;
            sample_data  <= dut_out;
            signature    <= rotl1(signature) ^ SIG_W'(dut_out);
            ones_count   <= ones_count + (N_IN+1)'(dut_out[0]);
            if (last_vec_s) begin
              state_r <= ST_FINISH;
              vec_out <= {N_IN{1'b0}};
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              vec_out <= vec_out + N_IN'(1);
            end
          end else begin
            state_r <= ST_SETTLE;
          end
        end
        ST_FINISH: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          vec_out <= {N_IN{1'b0}};
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
